// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports 0/1 plus data-memory pins; slave = arbiter side, master = requester/memory side
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic req0, we0, gnt0, rvalid0;
  logic req1, we1, gnt1, rvalid1;
  logic mem_ena, mem_we;
  logic [ADDR_W-1:0] addr0, addr1, mem_addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, mem_ena, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, mem_ena, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: one grant per clock onto the single-port data memory, core-priority with anti-starvation (CORE_PRIO=1) or round-robin (0); clk/rst plain, bus via dmem_arbiter_if.slave
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int CORE_PRIO = 1,
  parameter int MAX_WAIT  = 4
) (
  input logic clk,
  input logic rst,
  dmem_arbiter_if.slave bus
);
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
  logic last_q, last_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] rv_q, rv_d;
  logic gnt0, gnt1, pick1;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    pick1 = CORE_PRIO != 0 ? wait_cnt_q == MAX_W : !last_q;
    gnt1 = !rst && bus.req1 && (!bus.req0 || pick1);
    gnt0 = !rst && bus.req0 && !gnt1;
    last_d = gnt0 || gnt1 ? gnt1 : last_q;
    wait_cnt_d = !bus.req1 || gnt1 ? 4'd0 : wait_cnt_q == MAX_W ? wait_cnt_q : wait_cnt_q + 4'd1;
    rv_d = {gnt1 && !bus.we1, gnt0 && !bus.we0};
    addr = gnt1 ? bus.addr1 : bus.addr0;
    wdata = gnt1 ? bus.wdata1 : bus.wdata0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      wait_cnt_q <= '0;
      rv_q <= '0;
    end else begin
      last_q <= last_d;
      wait_cnt_q <= wait_cnt_d;
      rv_q <= rv_d;
    end
  end
  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;
  assign bus.rvalid0 = rv_q[0] && !rst;
  assign bus.rvalid1 = rv_q[1] && !rst;
  assign bus.rdata = bus.mem_rdata;
  assign bus.mem_ena = gnt0 || gnt1;
  assign bus.mem_we = gnt1 ? bus.we1 : gnt0 && bus.we0;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench driving a round-robin and a core-priority arbiter with identical directed stimulus
module tb_dmem_arbiter;
  typedef struct { logic g0, g1, we; logic [9:0] addr; logic [31:0] wd; } gexp_t;
  typedef struct { logic port; logic [31:0] data; int cyc; } rexp_t;
  localparam logic [1:0] N = 2'd0, P0 = 2'd1, P1 = 2'd2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  gexp_t gq[2][$];
  rexp_t rq[2][$];
  logic [31:0] gm[1024];
  logic [31:0] mm0[1024];
  logic [31:0] mm1[1024];
  logic [31:0] mrd0 = '0;
  logic [31:0] mrd1 = '0;
  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) ifa ();
  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) ifb ();
  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .CORE_PRIO(0), .MAX_WAIT(4)) dut_rr (.clk(clk), .rst(rst), .bus(ifa));
  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .CORE_PRIO(1), .MAX_WAIT(4)) dut_cp (.clk(clk), .rst(rst), .bus(ifb));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (ifa.mem_ena) begin
      if (ifa.mem_we) mm0[ifa.mem_addr] <= ifa.mem_wdata;
      else mrd0 <= mm0[ifa.mem_addr];
    end
  always @(posedge clk)
    if (ifb.mem_ena) begin
      if (ifb.mem_we) mm1[ifb.mem_addr] <= ifb.mem_wdata;
      else mrd1 <= mm1[ifb.mem_addr];
    end
  assign ifa.mem_rdata = mrd0;
  assign ifb.mem_rdata = mrd1;
  task automatic check(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask
  task automatic mon(int k, logic g0, logic g1, logic ena, logic we, logic [9:0] addr, logic [31:0] wd,
                     logic rv0, logic rv1, logic [31:0] rd);
    gexp_t g;
    rexp_t r;
    if (gq[k].size() > 0) begin
      g = gq[k].pop_front();
      check("gnt", k, 32'({g1, g0}), 32'({g.g1, g.g0}));
      check("mem_ena", k, 32'(ena), 32'(g.g0 | g.g1));
      check("mem_we", k, 32'(we), 32'(g.we));
      if (g.g0 | g.g1) check("mem_addr", k, 32'(addr), 32'(g.addr));
      if (g.we) check("mem_wdata", k, wd, g.wd);
    end
    if (rv0 | rv1) begin
      if (rq[k].size() == 0) check("unexpected_rvalid", k, 32'({rv1, rv0}), 32'd0);
      else begin
        r = rq[k].pop_front();
        check("rvalid_port", k, 32'({rv1, rv0}), r.port ? 32'd2 : 32'd1);
        check("rdata", k, rd, r.data);
        check("rvalid_cycle", k, 32'(cyc), 32'(r.cyc));
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0, ifa.gnt0, ifa.gnt1, ifa.mem_ena, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata, ifa.rvalid0, ifa.rvalid1, ifa.rdata);
    mon(1, ifb.gnt0, ifb.gnt1, ifb.mem_ena, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata, ifb.rvalid0, ifb.rvalid1, ifb.rdata);
  end
  task automatic drive(logic r0, logic w0, logic [9:0] a0, logic [31:0] d0, logic r1, logic w1, logic [9:0] a1, logic [31:0] d1);
    ifa.req0 = r0; ifa.we0 = w0; ifa.addr0 = a0; ifa.wdata0 = d0;
    ifa.req1 = r1; ifa.we1 = w1; ifa.addr1 = a1; ifa.wdata1 = d1;
    ifb.req0 = r0; ifb.we0 = w0; ifb.addr0 = a0; ifb.wdata0 = d0;
    ifb.req1 = r1; ifb.we1 = w1; ifb.addr1 = a1; ifb.wdata1 = d1;
  endtask
  task automatic step(logic rs, logic r0, logic w0, logic [9:0] a0, logic [31:0] d0,
                      logic r1, logic w1, logic [9:0] a1, logic [31:0] d1, logic [1:0] ea, logic [1:0] eb);
    gexp_t g;
    rexp_t r;
    logic [1:0] e;
    @(posedge clk);
    #1;
    if (rs)
      for (int k = 0; k < 2; k++)
        while (rq[k].size() > 0 && rq[k][rq[k].size() - 1].cyc == cyc) rq[k].pop_back();
    rst = rs;
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    for (int k = 0; k < 2; k++) begin
      e = k == 0 ? ea : eb;
      g.g0 = e[0];
      g.g1 = e[1];
      g.we = e[0] ? w0 : e[1] ? w1 : 1'b0;
      g.addr = e[1] ? a1 : a0;
      g.wd = e[1] ? d1 : d0;
      gq[k].push_back(g);
      if (e != N && !g.we) begin
        r.port = e[1];
        r.data = gm[g.addr];
        r.cyc = cyc + 1;
        rq[k].push_back(r);
      end
    end
    if (ea[0] && w0) gm[a0] = d0;
    if (ea[1] && w1) gm[a1] = d1;
  endtask
  task automatic both(logic rs, logic [1:0] ea, logic [1:0] eb);
    step(rs, 1'b1, 1'b0, 10'h010, 32'd0, 1'b1, 1'b0, 10'h020, 32'd0, ea, eb);
  endtask
  task automatic only0(logic rs, logic [9:0] a, logic [1:0] e);
    step(rs, 1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, e, e);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, N, N);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) begin
      gm[i] = 32'hC0DE_0000 + 32'(i);
      mm0[i] = gm[i];
      mm1[i] = gm[i];
    end
    gm[5] = 32'hDEAD_BEEF;
    mm0[5] = 32'hDEAD_BEEF;
    mm1[5] = 32'hDEAD_BEEF;
    drive(1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0);
    repeat (2) @(posedge clk);
    both(1'b1, N, N);
    both(1'b1, N, N);
    both(1'b0, P0, P0);
    both(1'b0, P1, P0);
    both(1'b0, P0, P0);
    both(1'b0, P1, P0);
    both(1'b0, P0, P1);
    both(1'b0, P1, P0);
    idle();
    only0(1'b0, 10'h005, P0);
    idle();
    step(1'b0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b1, 10'h003, 32'h1234_5678, P1, P1);
    only0(1'b0, 10'h003, P0);
    idle();
    only0(1'b0, 10'h005, P0);
    both(1'b1, N, N);
    both(1'b1, N, N);
    only0(1'b0, 10'h005, P0);
    idle();
    both(1'b0, P1, P0);
    both(1'b0, P0, P0);
    both(1'b0, P1, P0);
    only0(1'b0, 10'h007, P0);
    both(1'b0, P1, P0);
    both(1'b0, P0, P0);
    both(1'b0, P1, P0);
    both(1'b0, P0, P0);
    both(1'b0, P1, P1);
    idle();
    idle();
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("pending_rvalids", k, 32'(rq[k].size()), 32'd0);
      check("pending_grants", k, 32'(gq[k].size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 1024x32 data memory.
- Requester 0 is the core load/store path. Requester 1 is the program loader / debug DMA path.
- Sits between both requesters and the data memory's ena/we/addr/din/dout pins. Grants at most one access per clock.
- Returns read data with the memory's fixed one-cycle latency, tagged to the granted requester.

Parameters:
- ADDR_W, 10, word-address width into data memory.
- DATA_W, 32, data width.
- CORE_PRIO, 1, selects the arbitration policy. 1 = core fixed priority with anti-starvation. 0 = pure round-robin.
- MAX_WAIT, 4, when CORE_PRIO=1: number of consecutive denied cycles of requester 1 that forces a grant to it. Range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  core access request.
- we0  in  1  core write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  core word address.
- wdata0  in  DATA_W  core write data.
- gnt0  out  1  core access accepted this cycle.
- rvalid0  out  1  core read data valid.
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  loader request, same meaning as port 0.
- gnt1  out  1  loader access accepted this cycle.
- rvalid1  out  1  loader read data valid.
- rdata  out  DATA_W  read data; shared by both ports, qualified by rvalid0/rvalid1.
- mem_ena  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read-enabled edge.

Behaviour:
- Grant decision is combinational from req0/req1 and registered state. A request is accepted in the cycle its gnt is high. A requester must hold req/we/addr/wdata stable until granted.
- At most one of gnt0/gnt1 is high. gntN is never high without reqN.
- Memory drive:
  - mem_ena = gnt0|gnt1.
  - mem_we = we of the granted port.
  - mem_addr and mem_wdata are muxed from the granted port.
  - With no grant: mem_we=0; addr/wdata hold port 0 values (don't-care).
- Read response: a granted read (we=0) asserts rvalidN exactly one cycle later, one cycle wide. rdata = mem_rdata in that cycle. A granted write produces no rvalid. Back-to-back grants give back-to-back rvalids, interleaved per port in grant order.
- State registers:
  - last: 1 bit, the most recently granted port.
  - wait_cnt: 4 bits.
  - rv_q[1:0]: pending read-valid per port.
- Round-robin (CORE_PRIO=0):
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port != last.
  - last updates on every grant.
- Core priority (CORE_PRIO=1):
  - Both requesting: grant port 0, unless wait_cnt == MAX_WAIT, in which case grant port 1.
  - wait_cnt increments (saturating at MAX_WAIT) each cycle req1 is high and gnt1 is low.
  - wait_cnt clears to 0 on any gnt1 or when req1 is low.
- Reset (rst=1 at an edge):
  - last=1, so port 0 wins the first tie in either mode.
  - wait_cnt=0, rv_q=0.
  - Cycle after reset: rvalid0=rvalid1=0.
- While rst is high:
  - gnt0=gnt1=0 and mem_ena=0; no access is issued.
  - An in-flight read whose response falls in a reset cycle is discarded: its rvalid stays 0.
- Simultaneous same-address read by one port and write by the other: serialized by grant order. The read returns the memory's content at its own grant edge.

Test Plan:
- Reset then idle: rst high 2 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_ena=0 throughout. First cycle after release -> gnt0=1.
- Single read: req0=1, we0=0, addr0=10'h005, mem model returns 32'hDEAD_BEEF -> gnt0=1 in cycle N, mem_addr=5. rvalid0=1 with rdata=DEADBEEF in N+1. rvalid1=0.
- Round-robin (CORE_PRIO=0): both ports hold read requests 6 cycles -> grants alternate 0,1,0,1,0,1. rvalids alternate one cycle later with the correct per-address data.
- Anti-starvation (CORE_PRIO=1, MAX_WAIT=4): both request continuously -> gnt0 for 4 cycles, gnt1 in cycle 5, then gnt0 again. wait_cnt returns to 0 after gnt1.
- Write then read: port 1 writes 32'h1234_5678 to addr 3, port 0 reads addr 3 next cycle -> mem_we=1 on the first grant, no rvalid1. rvalid0 returns 12345678.
- Reset mid-read: read granted in cycle N, rst=1 in cycle N+1 -> rvalid0 stays 0. No grant during reset.
